// File: rtl/fir_decim_avg.sv
// ---------------------------------------------------------------------------
// fir_decim_avg
//
// Block-average decimator placed behind a FIR filter. Every DECIM accepted
// samples are summed and divided by DECIM (arithmetic shift). The result is
// pushed into a small output FIFO that feeds an AXI-Stream style master port.
// The input side has no backpressure: if the FIFO is full when a result is
// produced and no pop happens in the same cycle, the result is dropped and
// the sticky ovf_flag is raised.
//
// Build option:
//   FIR_DECIM_ROUND_EN  defined   -> round half up before the shift
//                       undefined -> plain truncating arithmetic shift
//
// Parameters:
//   DATA_W      sample width, signed two's complement
//   DECIM       decimation ratio (2, 4, 8 or 16)
//   FIFO_DEPTH  output FIFO entries (power of two, 2..32)
//
// Ports:
//   aclk                sole clock, rising edge
//   aresetn             asynchronous active-low reset
//   s_axis_data_tvalid  input sample strobe (always accepted)
//   s_axis_data_tdata   signed input sample
//   m_axis_data_tvalid  FIFO non-empty
//   m_axis_data_tready  downstream accept
//   m_axis_data_tdata   FIFO head (zero while empty)
//   ovf_flag            sticky: a result was dropped on a full FIFO
// ---------------------------------------------------------------------------
module fir_decim_avg #(
  parameter int DATA_W     = 16,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              s_axis_data_tvalid,
  input  logic [DATA_W-1:0] s_axis_data_tdata,
  output logic              m_axis_data_tvalid,
  input  logic              m_axis_data_tready,
  output logic [DATA_W-1:0] m_axis_data_tdata,
  output logic              ovf_flag
);

  localparam int SHIFT = $clog2(DECIM);
  localparam int ACC_W = DATA_W + SHIFT;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (DECIM != 2 && DECIM != 4 && DECIM != 8 && DECIM != 16) begin : g_bad_decim
    $error("fir_decim_avg: DECIM must be 2, 4, 8 or 16");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 32 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fir_decim_avg: FIFO_DEPTH must be a power of two in 2..32");
  end

  // -------------------------------------------------------------------------
  // Averaging datapath
  // -------------------------------------------------------------------------
  logic [SHIFT-1:0]        phase;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] sum;
  logic [DATA_W-1:0]       result;
  logic                    last_phase;

  assign last_phase = (phase == SHIFT'(DECIM - 1));
  assign sample_ext = {{SHIFT{s_axis_data_tdata[DATA_W-1]}}, s_axis_data_tdata};
  // The accumulator is wide enough for DECIM full-scale samples, so the sum
  // can never wrap.
  assign sum        = acc + sample_ext;

`ifdef FIR_DECIM_ROUND_EN
  // One extra bit keeps the half-LSB bias from wrapping a full-scale sum.
  localparam logic signed [ACC_W:0] RND = (ACC_W + 1)'(1) << (SHIFT - 1);
  logic signed [ACC_W:0] sum_rnd;
  assign sum_rnd = $signed({sum[ACC_W-1], sum}) + RND;
  assign result  = DATA_W'(sum_rnd >>> SHIFT);
`else
  assign result  = DATA_W'(sum >>> SHIFT);
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      phase <= '0;
      acc   <= '0;
    end else if (s_axis_data_tvalid) begin
      if (last_phase) begin
        phase <= '0;
        acc   <= '0;
      end else begin
        phase <= phase + 1'b1;
        acc   <= sum;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output FIFO
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              wr_en;
  logic              drop;

  assign push  = s_axis_data_tvalid && last_phase;
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign pop   = !empty && m_axis_data_tready;
  // A full FIFO still takes the new result when the head leaves this cycle.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  // NOTE: the storage array is deliberately left out of reset; validity is
  // carried by count, and the output mux forces zero while empty.
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem[wr_ptr] <= result;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf_flag <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        ovf_flag <= 1'b1;
      end
    end
  end

  // tvalid comes from the registered count, so a push into an empty FIFO
  // becomes visible one cycle later.
  assign m_axis_data_tvalid = !empty;
  assign m_axis_data_tdata  = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_fir_decim_avg.sv
// ---------------------------------------------------------------------------
// tb_fir_decim_avg
//
// Self-checking bench for fir_decim_avg at default parameters. A queue-based
// reference model (block average via integer floor division, FIFO as a
// queue) is compared against the DUT every cycle; a vector table covers the
// averaging/rounding corners, and hand-written sequences cover overflow,
// full-with-pop and reset mid-block. Expectations follow FIR_DECIM_ROUND_EN
// when the bench is compiled with that macro.
// ---------------------------------------------------------------------------
module tb_fir_decim_avg;

  localparam int DATA_W     = 16;
  localparam int DECIM      = 4;
  localparam int FIFO_DEPTH = 8;

  logic              aclk;
  logic              aresetn;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              ovf;

  fir_decim_avg #(
    .DATA_W    (DATA_W),
    .DECIM     (DECIM),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .s_axis_data_tvalid(s_valid),
    .s_axis_data_tdata (s_data),
    .m_axis_data_tvalid(m_valid),
    .m_axis_data_tready(m_ready),
    .m_axis_data_tdata (m_data),
    .ovf_flag          (ovf)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  longint            blk[$];
  logic [DATA_W-1:0] mq[$];
  bit                m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint model_avg(input longint s);
`ifdef FIR_DECIM_ROUND_EN
    return floor_div(s + DECIM / 2, DECIM);
`else
    return floor_div(s, DECIM);
`endif
  endfunction

  function automatic logic [DATA_W-1:0] head_exp();
    if (mq.size() == 0) return '0;
    return mq[0];
  endfunction

  // One clock: drive inputs, step the model, compare outputs #1 after the edge.
  task automatic do_cycle(input logic v, input logic [DATA_W-1:0] d, input logic rdy);
    bit     pop_m;
    bit     push_m;
    bit     full_before;
    longint s;
    longint res;
    s_valid = v;
    s_data  = d;
    m_ready = rdy;
    pop_m   = (mq.size() != 0) && rdy;
    push_m  = 1'b0;
    res     = 0;
    if (v) begin
      blk.push_back(longint'($signed(d)));
      if (blk.size() == DECIM) begin
        s = 0;
        foreach (blk[i]) s += blk[i];
        res = model_avg(s);
        blk.delete();
        push_m = 1'b1;
      end
    end
    full_before = (mq.size() == FIFO_DEPTH);
    @(posedge aclk);
    #1;
    if (pop_m) void'(mq.pop_front());
    if (push_m) begin
      if (!full_before || pop_m) mq.push_back(DATA_W'(res));
      else m_ovf = 1'b1;
    end
    check("tvalid", 32'(m_valid), 32'(mq.size() != 0));
    check("tdata", 32'(m_data), 32'(head_exp()));
    check("ovf_flag", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    check("rst_tvalid", 32'(m_valid), 32'd0);
    check("rst_tdata", 32'(m_data), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    aresetn = 1'b1;
    blk.delete();
    mq.delete();
    m_ovf = 1'b0;
  endtask

  // Pop with tready=1 and count entries seen; bounded by a cycle budget.
  task automatic drain(input string name, input int expected);
    int c;
    c = 0;
    for (int i = 0; i < 3 * FIFO_DEPTH; i++) begin
      if (m_valid) c++;
      do_cycle(1'b0, '0, 1'b1);
    end
    check(name, 32'(c), 32'(expected));
  endtask

  typedef struct {
    longint s [DECIM];
    longint exp_t;
    longint exp_r;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [DATA_W-1:0] e;

    tbl[0].s = '{100, 200, 300, 400};         tbl[0].exp_t = 250;    tbl[0].exp_r = 250;
    tbl[1].s = '{-1, -1, -1, -2};             tbl[1].exp_t = -2;     tbl[1].exp_r = -1;
    tbl[2].s = '{32767, 32767, 32767, 32767}; tbl[2].exp_t = 32767;  tbl[2].exp_r = 32767;
    tbl[3].s = '{-32768, -32768, -32768, -32768}; tbl[3].exp_t = -32768; tbl[3].exp_r = -32768;
    tbl[4].s = '{1, 2, 3, 4};                 tbl[4].exp_t = 2;      tbl[4].exp_r = 3;
    tbl[5].s = '{-3, 0, 0, 0};                tbl[5].exp_t = -1;     tbl[5].exp_r = -1;
    tbl[6].s = '{5, -5, 7, -6};               tbl[6].exp_t = 0;      tbl[6].exp_r = 0;

    aresetn = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    m_ovf   = 1'b0;
    #1;
    do_reset();

    // Vector table: four samples, result visible the cycle after the fourth.
    foreach (tbl[k]) begin
      for (int j = 0; j < DECIM; j++) begin
        if (j == DECIM - 1) check("tbl_tvalid_before", 32'(m_valid), 32'd0);
        do_cycle(1'b1, DATA_W'(tbl[k].s[j]), 1'b1);
      end
`ifdef FIR_DECIM_ROUND_EN
      e = DATA_W'(tbl[k].exp_r);
`else
      e = DATA_W'(tbl[k].exp_t);
`endif
      check("tbl_tvalid", 32'(m_valid), 32'd1);
      check("tbl_tdata", 32'(m_data), 32'(e));
      do_cycle(1'b0, '0, 1'b1);
    end

    // Overflow: 36 samples with tready low -> 8 held, 9th result dropped.
    do_reset();
    for (int i = 0; i < 9 * DECIM; i++) begin
      do_cycle(1'b1, DATA_W'(7), 1'b0);
      if (i == 8 * DECIM - 1) check("ovf_before_9th", 32'(ovf), 32'd0);
    end
    check("ovf_after_9th", 32'(ovf), 32'd1);
    check("ovf_head", 32'(m_data), 32'd7);
    drain("ovf_drain_count", FIFO_DEPTH);
    check("ovf_sticky", 32'(ovf), 32'd1);

    // Full FIFO with push and pop on the same edge.
    do_reset();
    for (int i = 0; i < FIFO_DEPTH * DECIM + DECIM - 1; i++) do_cycle(1'b1, DATA_W'(7), 1'b0);
    do_cycle(1'b1, DATA_W'(7), 1'b1);
    check("full_pushpop_ovf", 32'(ovf), 32'd0);
    drain("full_pushpop_count", FIFO_DEPTH);

    // Reset mid-block: the partial 5,5 block is discarded.
    do_reset();
    do_cycle(1'b1, DATA_W'(5), 1'b1);
    do_cycle(1'b1, DATA_W'(5), 1'b1);
    aresetn = 1'b0;
    #1;
    check("midrst_async_tvalid", 32'(m_valid), 32'd0);
    check("midrst_async_tdata", 32'(m_data), 32'd0);
    @(posedge aclk);
    #1;
    check("midrst_hold_tvalid", 32'(m_valid), 32'd0);
    aresetn = 1'b1;
    blk.delete();
    mq.delete();
    m_ovf = 1'b0;
    for (int i = 0; i < DECIM; i++) do_cycle(1'b1, DATA_W'(8), 1'b0);
    check("midrst_out", 32'(m_data), 32'd8);
    drain("midrst_count", 1);

    // Randomized traffic against the model; tready bias drops later to force drops.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic v;
      logic r;
      v = ($urandom % 4) != 0;
      r = ($urandom % 8) < ((i < 1500) ? 32'd5 : 32'd2);
      do_cycle(v, DATA_W'($urandom), r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fir_decim_avg.md
FIR_DECIM_AVG -- requirements
Module: fir_decim_avg

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, sample width (signed two's complement).
REQ-002 SHALL provide parameter DECIM, default 4, decimation ratio; legal values 2, 4, 8, 16 only.
REQ-003 SHALL provide parameter FIFO_DEPTH, default 8, output FIFO entries; power of two, 2..32.
REQ-004 SHALL provide port aclk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL provide port aresetn  input  1  asynchronous active-low reset.
REQ-006 SHALL provide port s_axis_data_tvalid  input  1  input sample strobe, driven by FIR output valid.
REQ-007 SHALL provide port s_axis_data_tdata  input  DATA_W  signed FIR output sample.
REQ-008 SHALL provide port m_axis_data_tvalid  output  1  decimated sample available.
REQ-009 SHALL provide port m_axis_data_tready  input  1  downstream accept.
REQ-010 SHALL provide port m_axis_data_tdata  output  DATA_W  signed decimated (averaged) sample.
REQ-011 SHALL provide port ovf_flag  output  1  sticky: a decimated result was dropped on full FIFO.

Function
REQ-012 SHALL have no input tready; every cycle with s_axis_data_tvalid=1 accepts one sample unconditionally.
REQ-013 SHALL keep phase counter 0..DECIM-1, incremented per accepted sample, wrapping DECIM-1 -> 0.
REQ-014 SHALL keep signed accumulator of DATA_W+log2(DECIM) bits; no overflow possible at that width.
REQ-015 SHALL, on accepted sample with phase<DECIM-1, add sample to accumulator.
REQ-016 SHALL, on accepted sample with phase=DECIM-1, form sum=acc+sample, result=sum>>>log2(DECIM) (arithmetic), push result to FIFO, clear acc to 0, same edge.
REQ-017 SHALL assert m_axis_data_tvalid the cycle after a push into an empty FIFO (no same-cycle fall-through).
REQ-018 SHALL present FIFO head on m_axis_data_tdata; tdata SHALL stay stable while tvalid=1 and tready=0.
REQ-019 SHALL pop head on cycle with tvalid=1 and tready=1; tvalid deasserts after last entry pops.
REQ-020 SHALL, when full and a push occurs without same-cycle pop, drop the result, set ovf_flag, leave FIFO unchanged.
REQ-021 SHALL, when full with simultaneous push and pop, perform both; no drop, ovf_flag unchanged.
REQ-022 SHALL, when empty, ignore tready; no pop, no underflow.
REQ-023 SHALL keep ovf_flag set until reset.
REQ-024 SHALL never block or stall the phase counter on FIFO state.

Reset
REQ-025 SHALL, on aresetn=0, immediately clear phase, accumulator, FIFO pointers/count, ovf_flag; m_axis_data_tvalid=0, m_axis_data_tdata=0.
REQ-026 SHALL discard any partial block on reset mid-block; first sample after release is phase 0.
REQ-027 SHALL accept samples on the first rising edge with aresetn=1.

Configuration
REQ-028 SHALL honour macro FIR_DECIM_ROUND_EN: defined -> result=(sum+2^(log2(DECIM)-1))>>>log2(DECIM) (round half up); undefined -> plain truncating arithmetic shift.
REQ-029 SHALL, with FIR_DECIM_ROUND_EN, produce no wrap: 4x32767 -> 32767 at DATA_W=16, DECIM=4.

Verification
REQ-030 SHALL verify basic average: DECIM=4, tready=1, inputs 100,200,300,400 -> one output 250, tvalid one cycle after 4th sample.
REQ-031 SHALL verify negative rounding: inputs -1,-1,-1,-2 -> -2 without FIR_DECIM_ROUND_EN, -1 with it.
REQ-032 SHALL verify extremes: 4x32767 -> 32767; 4x-32768 -> -32768; both build variants.
REQ-033 SHALL verify overflow: tready=0, 36 samples of value 7 -> 8 entries of 7 held, ovf_flag=1 after 9th result; tready=1 drains exactly 8.
REQ-034 SHALL verify full with simultaneous push/pop: FIFO full, tready=1 on the 4th-sample cycle -> count stays 8, ovf_flag=0.
REQ-035 SHALL verify reset mid-block: samples 5,5, aresetn pulse, then 8,8,8,8 -> single output 8, tvalid=0 during reset.
